// File: rtl/lj_lut_addr_gen_pkg.sv
// Shared constants and types for the LJ coefficient table address generator.
// Covers the table geometry, the IEEE-754 field positions and the output record.
package lj_lut_pkg;

  localparam int LJ_SEGMENTS  = 12;
  localparam int LJ_BIN_BITS  = 8;
  localparam int LJ_MIN_EXP   = 118;
  localparam int LJ_FRAC_W    = 23 - LJ_BIN_BITS;
  localparam int LJ_LUT_DEPTH = LJ_SEGMENTS * (2 ** LJ_BIN_BITS);

  localparam int LJ_SIGN_BIT = 31;
  localparam int LJ_EXP_MSB  = 30;
  localparam int LJ_EXP_LSB  = 23;
  localparam int LJ_MANT_MSB = 22;

  typedef struct packed {
    logic [31:0]          coef;
    logic [LJ_FRAC_W-1:0] frac;
    logic                 low_clamp;
    logic                 cutoff;
  } lj_lut_out_t;

endpackage

// File: rtl/lj_lut_addr_gen_if.sv
// Input (ivalid/iready) and output (ovalid/oready) stream of the LJ table stage.
// The block under the slave modport consumes r2 and produces coef/frac/flags.
interface lj_lut_addr_gen_if
  import lj_lut_pkg::*;
#(
  parameter int FRAC_W = LJ_FRAC_W
) ();
  logic              ivalid;
  logic              iready;
  logic [31:0]       r2;
  logic              ovalid;
  logic              oready;
  logic [31:0]       coef;
  logic [FRAC_W-1:0] frac;
  logic              low_clamp;
  logic              cutoff;

  modport master (
    output ivalid, r2, oready,
    input  iready, ovalid, coef, frac, low_clamp, cutoff
  );

  modport slave (
    input  ivalid, r2, oready,
    output iready, ovalid, coef, frac, low_clamp, cutoff
  );
endinterface

// File: rtl/lj_lut_skid_fifo.sv
// Small synchronous FIFO with occupancy count; absorbs table results that
// cannot stall while the downstream interpolator applies back-pressure.
module lj_lut_skid_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/lj_lut_addr_gen.sv
// Splits an fp32 r^2 into segment/bin table address, tracks the 2-cycle table
// read with a shadow pipeline and buffers results in a credit-managed FIFO.
module lj_lut_addr_gen
  import lj_lut_pkg::*;
#(
  parameter int SEGMENTS   = LJ_SEGMENTS,
  parameter int BIN_BITS   = LJ_BIN_BITS,
  parameter int MIN_EXP    = LJ_MIN_EXP,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAC_W     = LJ_FRAC_W
) (
  input  logic                  clock,
  input  logic                  resetn,
  lj_lut_addr_gen_if.slave      strm,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic                  lut_rden,
  input  logic [31:0]           lut_q
);
  localparam int ENTRY_W = 32 + FRAC_W + 2;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [FRAC_W-1:0]     frac;
    logic                  low_clamp;
    logic                  cutoff;
  } lut_req_t;

  // Below-range inputs clamp to address 0; anything beyond the table, negative,
  // Inf or NaN maps to the all-ones address and is zeroed downstream.
  function automatic lut_req_t map_r2(input logic [31:0] v);
    lut_req_t r;
    int       seg;
    r   = '0;
    seg = int'(v[LJ_EXP_MSB:LJ_EXP_LSB]) - MIN_EXP;
    if (v[LJ_SIGN_BIT] || (v[LJ_EXP_MSB:LJ_EXP_LSB] == 8'hFF) || (seg >= SEGMENTS)) begin
      r.addr   = '1;
      r.cutoff = 1'b1;
    end else if (seg < 0) begin
      r.low_clamp = 1'b1;
    end else begin
      r.addr = ADDR_WIDTH'(seg * (2 ** BIN_BITS) + int'(v[LJ_MANT_MSB -: BIN_BITS]));
      r.frac = v[FRAC_W-1:0];
    end
    return r;
  endfunction

  logic                  accept;
  lut_req_t              req;
  logic                  vld_p1_q, vld_p1_d, vld_p2_q, vld_p3_q;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d;
  logic [FRAC_W-1:0]     frac_p1_q, frac_p1_d, frac_p2_q, frac_p3_q;
  logic                  low_p1_q, low_p1_d, low_p2_q, low_p3_q;
  logic                  cut_p1_q, cut_p1_d, cut_p2_q, cut_p3_q;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_empty;
  logic                  fifo_rd;

  // Credits cover every result already committed to arrive, since the table cannot stall.
  assign strm.iready = (int'(fifo_count) + int'(vld_p1_q) + int'(vld_p2_q)
                        + int'(vld_p3_q)) < FIFO_DEPTH;

  always_comb begin
    accept    = strm.ivalid && strm.iready;
    req       = map_r2(strm.r2);
    vld_p1_d  = accept;
    addr_p1_d = accept ? req.addr      : addr_p1_q;
    frac_p1_d = accept ? req.frac      : frac_p1_q;
    low_p1_d  = accept ? req.low_clamp : low_p1_q;
    cut_p1_d  = accept ? req.cutoff    : cut_p1_q;
  end

  // Stage p1: address register; p2: table address reg; p3: table output reg.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      addr_p1_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      addr_p1_q <= addr_p1_d;
    end
  end

  always_ff @(posedge clock) begin
    frac_p1_q <= frac_p1_d;
    low_p1_q  <= low_p1_d;
    cut_p1_q  <= cut_p1_d;
    frac_p2_q <= frac_p1_q;
    low_p2_q  <= low_p1_q;
    cut_p2_q  <= cut_p1_q;
    frac_p3_q <= frac_p2_q;
    low_p3_q  <= low_p2_q;
    cut_p3_q  <= cut_p2_q;
  end

  assign lut_address = addr_p1_q;
  assign lut_rden    = vld_p1_q;

  // Output stage: FIFO head drives the stream; fields read as zero while empty.
  lj_lut_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (vld_p3_q),
    .wr_data ({lut_q, frac_p3_q, low_p3_q, cut_p3_q}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign fifo_empty     = (fifo_count == '0);
  assign fifo_rd        = !fifo_empty && strm.oready;
  assign strm.ovalid    = !fifo_empty;
  assign strm.coef      = fifo_empty ? '0   : fifo_head[ENTRY_W-1 -: 32];
  assign strm.frac      = fifo_empty ? '0   : fifo_head[FRAC_W+1:2];
  assign strm.low_clamp = fifo_empty ? 1'b0 : fifo_head[1];
  assign strm.cutoff    = fifo_empty ? 1'b0 : fifo_head[0];
endmodule

// File: tb/tb_lj_lut_addr_gen.sv
// Directed and randomised-flow checks of lj_lut_addr_gen against a table model
// and an independent address/flag scoreboard.
module tb_lj_lut_addr_gen;
  import lj_lut_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] lut_address;
  logic        lut_rden;
  logic [31:0] lut_q;
  logic [11:0] rom_addr_q;

  lj_lut_addr_gen_if #(.FRAC_W(15)) sif ();

  lj_lut_addr_gen u_dut (
    .clock       (clock),
    .resetn      (resetn),
    .strm        (sif.slave),
    .lut_address (lut_address),
    .lut_rden    (lut_rden),
    .lut_q       (lut_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {a, 4'h5, ~a, 4'hC};
  endfunction

  // Table: registered address, registered output.
  always_ff @(posedge clock) begin
    if (lut_rden) rom_addr_q <= lut_address;
    lut_q <= rom_word(rom_addr_q);
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_full_wr = 0;
  bit rnd_rdy = 0;
  lj_lut_out_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_cut(input logic [31:0] v);
    int e;
    e = int'(v[30:23]);
    return v[31] || e == 255 || e >= 118 + 12;
  endfunction

  function automatic logic [11:0] exp_addr(input logic [31:0] v);
    int e;
    e = int'(v[30:23]);
    if (is_cut(v)) return 12'hFFF;
    if (e < 118) return 12'h000;
    return 12'((e - 118) * 256 + int'(v[22:15]));
  endfunction

  function automatic lj_lut_out_t model(input logic [31:0] v);
    lj_lut_out_t o;
    o.cutoff    = is_cut(v);
    o.low_clamp = !o.cutoff && (int'(v[30:23]) < 118);
    o.frac      = (o.cutoff || o.low_clamp) ? 15'd0 : v[14:0];
    o.coef      = rom_word(exp_addr(v));
    return o;
  endfunction

  // Scoreboard: accepts and output transfers are sampled mid-cycle.
  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      if (u_dut.u_fifo.wr_en && (u_dut.u_fifo.count_q == 3'd4)) n_full_wr++;
      if (sif.ivalid && sif.iready) exp_q.push_back(model(sif.r2));
      if (sif.ovalid && sif.oready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          lj_lut_out_t e;
          e = exp_q.pop_front();
          chk("coef", sif.coef, e.coef);
          chk("frac", sif.frac, e.frac);
          chk("low_clamp", sif.low_clamp, e.low_clamp);
          chk("cutoff", sif.cutoff, e.cutoff);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rnd_rdy) sif.oready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] v);
    bit acc;
    acc = 0;
    sif.ivalid = 1'b1;
    sif.r2     = v;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      acc = sif.iready;
      step();
      if (acc) break;
    end
    sif.ivalid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int out0;
    logic [31:0] hold_coef;
    logic [31:0] v;
    sif.ivalid = 1'b0;
    sif.r2     = '0;
    sif.oready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("iready_in_reset", sif.iready, 1);
    chk("ovalid_in_reset", sif.ovalid, 0);
    resetn = 1'b1;
    step();
    chk("rst_iready", sif.iready, 1);
    chk("rst_ovalid", sif.ovalid, 0);
    chk("rst_lut_rden", lut_rden, 0);
    chk("rst_lut_address", lut_address, 0);
    chk("rst_coef", sif.coef, 0);
    chk("rst_frac", sif.frac, 0);
    chk("rst_flags", {sif.low_clamp, sif.cutoff}, 0);

    // 1.0: address and latency
    send(32'h3F800000);
    chk("addr_1p0", lut_address, 2304);
    chk("rden_1p0", lut_rden, 1);
    step();
    chk("rden_one_cycle", lut_rden, 0);
    chk("ovalid_e1", sif.ovalid, 0);
    step();
    chk("ovalid_e2", sif.ovalid, 0);
    step();
    chk("ovalid_e3", sif.ovalid, 1);
    chk("coef_1p0", sif.coef, rom_word(12'd2304));
    step();
    chk("ovalid_after_read", sif.ovalid, 0);

    send(32'h3FC00000);
    chk("addr_1p5", lut_address, 2432);
    send(32'h40FFFFFF);
    chk("addr_top", lut_address, 3071);
    drain();

    send(32'h3A800000);
    chk("addr_low", lut_address, 0);
    send(32'h41000000);
    chk("addr_8p0", lut_address, 4095);
    send(32'hBF800000);
    chk("addr_neg", lut_address, 4095);
    send(32'h7FC00000);
    chk("addr_nan", lut_address, 4095);
    drain();

    // Back-pressure: credits cap acceptance at the FIFO depth.
    sif.oready = 1'b0;
    sif.ivalid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      sif.r2 = 32'h3F800000 + (32'(i) << 15);
      @(negedge clock);
      if (sif.iready) n_acc++;
      step();
    end
    sif.ivalid = 1'b0;
    chk("accepted_when_blocked", n_acc, 4);
    chk("iready_when_full", sif.iready, 0);
    chk("ovalid_when_full", sif.ovalid, 1);
    hold_coef = sif.coef;
    repeat (3) step();
    chk("coef_hold", sif.coef, hold_coef);
    out0 = n_out;
    sif.oready = 1'b1;
    drain();
    chk("blocked_out_count", n_out - out0, 4);

    // Random in-range stream with random oready
    rnd_rdy = 1;
    out0 = n_out;
    for (int i = 0; i < 100; i++) begin
      v = {1'b0, 8'(118 + $urandom_range(0, 11)), 23'($urandom)};
      send(v);
    end
    drain();
    rnd_rdy = 0;
    sif.oready = 1'b1;
    step();
    chk("random_out_count", n_out - out0, 100);
    chk("full_fifo_writes", n_full_wr, 0);

    // Reset with 2 in the FIFO and 2 in flight
    sif.oready = 1'b0;
    send(32'h3F800000);
    send(32'h3F808000);
    repeat (3) step();
    send(32'h3F810000);
    send(32'h3F818000);
    chk("pre_reset_ovalid", sif.ovalid, 1);
    chk("pre_reset_iready", sif.iready, 0);
    resetn = 1'b0;
    #1;
    chk("reset_ovalid_drop", sif.ovalid, 0);
    chk("reset_iready", sif.iready, 1);
    step();
    step();
    resetn = 1'b1;
    step();
    chk("post_reset_iready", sif.iready, 1);
    chk("post_reset_rden", lut_rden, 0);
    sif.oready = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_reset_no_stale", sif.ovalid, 0);
    end
    chk("post_reset_out_count", n_out - out0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
